// File: rtl/fft_full.sv
// fft_full: 512-point in-place radix-2 DIT FFT over captured PCM, followed by a
// dominant-bin search below Nyquist and a band/threshold note decision.
module fft_full #(
  parameter int BIT_WIDTH  = 16,
  parameter int N          = 9,
  parameter int FFT_SIZE   = 512,
  parameter int FS         = 8000,
  parameter int F_MIN      = 80,
  parameter int F_MAX      = 2000,
  parameter int MAG_THRESH = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fft_load,
  input  logic [N-1:0]                add_rd,
  input  logic signed [BIT_WIDTH-1:0] din,
  input  logic                        fft_start,
  output logic                        noted
);
  typedef enum logic [2:0] {IDLE, FFT, SEARCH, DECIDE, DONE} state_t;
  localparam int SW = $clog2(N);
  localparam int PW = 2*BIT_WIDTH+1;
  state_t state_q;
  logic [SW-1:0] stage_q;
  logic [N-2:0] bfly_q, bin_q, peak_idx_q;
  logic [BIT_WIDTH:0] peak_mag_q, mag;
  logic signed [BIT_WIDTH-1:0] mem_re [FFT_SIZE];
  logic signed [BIT_WIDTH-1:0] mem_im [FFT_SIZE];
  logic signed [BIT_WIDTH-1:0] w_re [FFT_SIZE/2];
  logic signed [BIT_WIDTH-1:0] w_im [FFT_SIZE/2];
  logic [N-1:0] load_addr, top, bot;
  logic [N-2:0] lo_mask, tw;
  logic signed [BIT_WIDTH-1:0] xr_t, xi_t, xr_b, xi_b;
  logic signed [PW-1:0] pr, pi;
  logic signed [BIT_WIDTH:0] tr, ti, sr, si, dr, di, ar, ai;
  logic hit;
  int freq;
  // Twiddles W^m = cos - j*sin, rounded to nearest at elaboration
  for (genvar g = 0; g < FFT_SIZE/2; g++) begin : g_rom
    localparam real ANG = 2.0 * 3.14159265358979323846 * g / FFT_SIZE;
    localparam real CR  = 32767.0 * $cos(ANG);
    localparam real SR  = 32767.0 * $sin(ANG);
    localparam int  C   = $rtoi(CR < 0.0 ? CR - 0.5 : CR + 0.5);
    localparam int  S   = $rtoi(SR < 0.0 ? SR - 0.5 : SR + 0.5);
    assign w_re[g] = BIT_WIDTH'(C);
    assign w_im[g] = BIT_WIDTH'(-S);
  end
  always_comb begin
    for (int i = 0; i < N; i++) load_addr[i] = add_rd[N-1-i];
    lo_mask = (N-1)'((1 << stage_q) - 1);
    top = {bfly_q & ~lo_mask, 1'b0} | {1'b0, bfly_q & lo_mask};
    bot = top | N'(1 << stage_q);
    tw = (N-1)'((bfly_q & lo_mask) << (N - 1 - int'(stage_q)));
    xr_t = mem_re[top];
    xi_t = mem_im[top];
    xr_b = mem_re[bot];
    xi_b = mem_im[bot];
    pr = PW'(w_re[tw]) * PW'(xr_b) - PW'(w_im[tw]) * PW'(xi_b);
    pi = PW'(w_re[tw]) * PW'(xi_b) + PW'(w_im[tw]) * PW'(xr_b);
    tr = (BIT_WIDTH+1)'(pr >>> (BIT_WIDTH-1));
    ti = (BIT_WIDTH+1)'(pi >>> (BIT_WIDTH-1));
    sr = (BIT_WIDTH+1)'(xr_t) + tr;
    si = (BIT_WIDTH+1)'(xi_t) + ti;
    dr = (BIT_WIDTH+1)'(xr_t) - tr;
    di = (BIT_WIDTH+1)'(xi_t) - ti;
    ar = (BIT_WIDTH+1)'(mem_re[{1'b0, bin_q}]);
    ai = (BIT_WIDTH+1)'(mem_im[{1'b0, bin_q}]);
    mag = (ar[BIT_WIDTH] ? -ar : ar) + (ai[BIT_WIDTH] ? -ai : ai);
    freq = int'(peak_idx_q) * FS / FFT_SIZE;
    hit = int'(peak_mag_q) >= MAG_THRESH && freq >= F_MIN && freq <= F_MAX;
  end
  // Buffer has no reset; butterfly writes land on both legs in the same edge
  always_ff @(posedge clk) begin
    if (fft_load && (state_q == IDLE || state_q == DONE)) begin
      mem_re[load_addr] <= din;
      mem_im[load_addr] <= '0;
    end
    if (state_q == FFT) begin
      mem_re[top] <= sr[BIT_WIDTH:1];
      mem_im[top] <= si[BIT_WIDTH:1];
      mem_re[bot] <= dr[BIT_WIDTH:1];
      mem_im[bot] <= di[BIT_WIDTH:1];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      bfly_q     <= '0;
      bin_q      <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
      noted      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!fft_load && fft_start) begin
          state_q    <= FFT;
          stage_q    <= '0;
          bfly_q     <= '0;
          peak_mag_q <= '0;
          peak_idx_q <= '0;
          noted      <= 1'b0;
        end
        FFT: begin
          bfly_q <= bfly_q + 1'b1;
          if (&bfly_q) begin
            stage_q <= stage_q + 1'b1;
            if (stage_q == SW'(N-1)) begin
              state_q <= SEARCH;
              bin_q   <= (N-1)'(1);
            end
          end
        end
        SEARCH: begin
          if (mag > peak_mag_q) begin
            peak_mag_q <= mag;
            peak_idx_q <= bin_q;
          end
          bin_q <= bin_q + 1'b1;
          if (&bin_q) state_q <= DECIDE;
        end
        DECIDE: begin
          noted   <= hit;
          state_q <= DONE;
        end
        DONE: if (fft_load) begin
          state_q <= IDLE;
          noted   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_full.sv
// tb_fft_full: tone table, randomized tones and abort/re-arm sequences for fft_full,
// checked against a fixed-point FFT model written as plain array loops.
module tb_fft_full;
  localparam int NP = 512;
  localparam int FS = 5000;
  localparam int S_IDLE = 0;
  localparam int S_DONE = 4;
  localparam real PI = 3.14159265358979323846;
  typedef struct {
    int freq;
    int amp;
    bit exp_noted;
    int idx_lo;
    int idx_hi;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, fft_load = 1'b0, fft_start = 1'b0, noted;
  logic [8:0] add_rd = '0;
  logic signed [15:0] din = '0;
  int total = 0, bad = 0;
  int smp [NP];
  int wr [NP/2];
  int wi [NP/2];
  int exp_idx, exp_mag;
  bit exp_noted, got;
  vec_t tbl [6];

  fft_full #(.FS(FS)) dut (
    .clk(clk), .reset(reset), .fft_load(fft_load), .add_rd(add_rd),
    .din(din), .fft_start(fft_start), .noted(noted)
  );

  always #5 clk = ~clk;

  function automatic int rnd(input real v);
    return $rtoi(v < 0.0 ? v - 0.5 : v + 0.5);
  endfunction

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < 9; b++) if (((v >> b) & 1) != 0) r |= 1 << (8 - b);
    return r;
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic gen(input int f, input int amp, input int noise);
    real v;
    for (int i = 0; i < NP; i++) begin
      v = amp * $sin(2.0 * PI * f * i / FS);
      smp[i] = rnd(v);
      if (noise > 0) smp[i] += int'($urandom_range(2 * noise, 0)) - noise;
    end
  endtask

  // Reference: scaled DIT FFT over a bit-reversed copy, then peak search and decision
  task automatic model();
    int re [NP];
    int im [NP];
    longint tr, ti, a, c;
    int h, j, t, b, m, mg, fr;
    for (int i = 0; i < NP; i++) begin
      re[bitrev(i)] = smp[i];
      im[i] = 0;
    end
    for (int s = 0; s < 9; s++) begin
      h = 1 << s;
      for (int k = 0; k < NP/2; k++) begin
        j = k % h;
        t = (k / h) * 2 * h + j;
        b = t + h;
        m = j << (8 - s);
        tr = (longint'(wr[m]) * re[b] - longint'(wi[m]) * im[b]) >>> 15;
        ti = (longint'(wr[m]) * im[b] + longint'(wi[m]) * re[b]) >>> 15;
        a = re[t];
        c = im[t];
        re[t] = int'((a + tr) >>> 1);
        im[t] = int'((c + ti) >>> 1);
        re[b] = int'((a - tr) >>> 1);
        im[b] = int'((c - ti) >>> 1);
      end
    end
    exp_idx = 0;
    exp_mag = 0;
    for (int k = 1; k < NP/2; k++) begin
      mg = iabs(re[k]) + iabs(im[k]);
      if (mg > exp_mag) begin
        exp_mag = mg;
        exp_idx = k;
      end
    end
    fr = exp_idx * FS / NP;
    exp_noted = exp_mag >= 64 && fr >= 80 && fr <= 2000;
  endtask

  task automatic load(input bit st);
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      fft_load = 1'b1;
      fft_start = st;
      add_rd = 9'(i);
      din = 16'(smp[i]);
    end
    @(negedge clk);
    fft_load = 1'b0;
  endtask

  task automatic run(input string tag, output bit nt);
    int hi = 0;
    fft_start = 1'b1;
    @(posedge clk);
    #1 fft_start = 1'b0;
    for (int e = 1; e <= 2560; e++) begin
      @(posedge clk);
      #1;
      if (e < 2560 && noted) hi++;
    end
    check({tag, " noted low while busy"}, hi, 0);
    check({tag, " state done"}, int'(dut.state_q), S_DONE);
    nt = noted;
  endtask

  task automatic check_peaks(input string tag);
    check({tag, " peak_idx"}, int'(dut.peak_idx_q), exp_idx);
    check({tag, " peak_mag"}, int'(dut.peak_mag_q), exp_mag);
  endtask

  initial begin
    int hi;
    for (int m = 0; m < NP/2; m++) begin
      wr[m] = rnd(32767.0 * $cos(2.0 * PI * m / NP));
      wi[m] = -rnd(32767.0 * $sin(2.0 * PI * m / NP));
    end
    tbl[0] = '{1000, 16384, 1'b1, 102, 103};
    tbl[1] = '{0,    0,     1'b0, 0,   0};
    tbl[2] = '{40,   16384, 1'b0, 4,   4};
    tbl[3] = '{1500, 16384, 1'b1, 153, 154};
    tbl[4] = '{2200, 16384, 1'b0, 224, 226};
    tbl[5] = '{1000, 32,    1'b0, 0,   255};

    #12;
    check("reset noted", int'(noted), 0);
    check("reset state", int'(dut.state_q), S_IDLE);
    @(negedge clk) reset = 1'b0;
    hi = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (noted) hi++;
    end
    check("idle noted", hi, 0);

    for (int v = 0; v < 6; v++) begin
      gen(tbl[v].freq, tbl[v].amp, 0);
      model();
      load(1'b0);
      run($sformatf("tbl%0d", v), got);
      check($sformatf("tbl%0d noted", v), int'(got), int'(tbl[v].exp_noted));
      check($sformatf("tbl%0d idx in range", v),
            int'(dut.peak_idx_q >= 8'(tbl[v].idx_lo) && dut.peak_idx_q <= 8'(tbl[v].idx_hi)), 1);
      check_peaks($sformatf("tbl%0d", v));
      if (v == 0) check("tone peak_mag > 4000", int'(dut.peak_mag_q > 17'd4000), 1);
    end

    for (int r = 0; r < 3; r++) begin
      gen(int'($urandom_range(2450, 30)), int'($urandom_range(16384, 0)), 16);
      model();
      load(1'b0);
      run($sformatf("rnd%0d", r), got);
      check($sformatf("rnd%0d noted", r), int'(got), int'(exp_noted));
      check_peaks($sformatf("rnd%0d", r));
    end

    gen(1000, 16384, 0);
    load(1'b0);
    fft_start = 1'b1;
    @(posedge clk);
    #1 fft_start = 1'b0;
    repeat (1000) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort noted", int'(noted), 0);
    check("abort state", int'(dut.state_q), S_IDLE);
    @(negedge clk) reset = 1'b0;
    load(1'b0);
    run("reload", got);
    check("reload noted", int'(got), 1);
    @(negedge clk) fft_start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("done hold noted", int'(noted), 1);
    check("done hold state", int'(dut.state_q), S_DONE);

    @(negedge clk);
    fft_start = 1'b0;
    fft_load = 1'b1;
    add_rd = '0;
    din = '0;
    @(posedge clk);
    #1;
    check("rearm noted", int'(noted), 0);
    check("rearm state", int'(dut.state_q), S_IDLE);
    gen(0, 0, 0);
    model();
    load(1'b1);
    check("load priority state", int'(dut.state_q), S_IDLE);
    run("zero", got);
    check("zero noted", int'(got), 0);
    check_peaks("zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_full.md
# fft_full

Single-clock 512-point audio FFT plus note-presence detector. The capture path writes one block of real PCM samples into an internal buffer. An in-place radix-2 FFT then runs over the buffer, followed by a search for the dominant bin below Nyquist. The block asserts `noted` when the dominant tone is strong enough and lies within the musical band. It sits between the sample-capture logic and the note-decode/display logic.

## Interface
- `BIT_WIDTH`, 16: sample/real/imag word width, signed Q1.15.
- `N`, 9: log2(FFT_SIZE); stage count and address width.
- `FFT_SIZE`, 512: transform length.
- `FS`, 8000: sample rate in Hz, used for bin→frequency conversion.
- `F_MIN`, 80 / `F_MAX`, 2000: accepted peak-frequency band in Hz, inclusive.
- `MAG_THRESH`, 64: minimum peak magnitude.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `fft_load` in 1: sample-write enable.
- `add_rd` in N: sample index for the write.
- `din` in BIT_WIDTH: signed real sample.
- `fft_start` in 1: level request to transform the buffer.
- `noted` out 1: registered; note detected in the last completed block.

## Operation
- Storage: FFT_SIZE complex words (re, im; BIT_WIDTH each). The array is not reset.
- Load (IDLE or DONE):
  - Each edge with `fft_load`=1 writes re=`din`, im=0 to address bitrev(`add_rd`), N-bit reversal.
  - In DONE, a load write also moves to IDLE and clears `noted`.
  - `fft_load` is ignored in FFT, SEARCH and DECIDE.
- States: IDLE, FFT, SEARCH, DECIDE, DONE.
  - IDLE→FFT on an edge with `fft_start`=1 and `fft_load`=0; `fft_load` has priority.
  - DONE holds regardless of `fft_start`.
- FFT, decimation-in-time, one butterfly per cycle:
  - Stage s = 0..N-1, butterfly k = 0..FFT_SIZE/2-1.
  - half = 2^s, j = k mod half, top = (k>>s)·2·half + j, bot = top + half.
  - Twiddle index m = j<<(N-1-s).
  - W = (round(32767·cos(2πm/FFT_SIZE)), -round(32767·sin(2πm/FFT_SIZE))), from a ROM of FFT_SIZE/2 entries.
  - Complex multiply t = W·X[bot]: full-precision products, each sum arithmetic-shifted right by 15.
  - X[top] = (X[top]+t)>>>1 and X[bot] = (X[top]−t)>>>1, using BIT_WIDTH+1-bit intermediates, then truncated. The per-stage scaling makes the total gain 1/FFT_SIZE.
  - Read is combinational and the write lands on the same edge.
- SEARCH: one bin per cycle over bins 1..FFT_SIZE/2-1.
  - mag = |re| + |im|, BIT_WIDTH+1 bits.
  - peak_mag/peak_idx update only on a strictly greater value, so the lowest index wins ties.
  - peak_mag and peak_idx start at 0.
- DECIDE:
  - freq = peak_idx·FS/FFT_SIZE, integer floor.
  - `noted` = (peak_mag ≥ MAG_THRESH) and (F_MIN ≤ freq ≤ F_MAX).
  - Then go to DONE.

## Timing
- Reset (async): state IDLE, stage/butterfly/bin counters 0, peak regs 0, `noted`=0.
  - Reset mid-FFT or mid-SEARCH aborts the run.
  - Buffer contents after an abort are unspecified; a reload is required.
- Edge 0 is the edge sampling `fft_start` in IDLE:
  - Butterflies occur on edges 1..2304 (N·FFT_SIZE/2).
  - SEARCH occupies edges 2305..2559.
  - DECIDE on edge 2560 updates `noted` and enters DONE.
- `noted` is 0 throughout FFT, SEARCH and DECIDE. It holds its DECIDE value in DONE until reset or a load write.
- A load write is one sample per edge; 512 consecutive edges fill the buffer.
- `din` and `add_rd` must be stable at each edge while `fft_load`=1.

## Test plan
- Reset: assert `reset`, check `noted`=0 and state IDLE; release, idle 20 cycles, `noted` stays 0.
- Tone in band:
  - Set FS=5000, load 512 samples of a 1000 Hz sine, amplitude 0x4000, then drop `fft_load` and raise `fft_start`.
  - `noted`=0 through edge 2559 and 1 at edge 2560.
  - peak_idx is 102 or 103; peak_mag > 4000.
- Silence: load all zeros, start → `noted`=0 after 3000 cycles, peak_mag=0.
- Out of band: FS=5000, 40 Hz sine, amplitude 0x4000 (bin 4, about 39 Hz) → `noted`=0 at edge 2560.
- Abort: during the 1000 Hz run, assert `reset` at edge 1000 → `noted`=0 and IDLE. Reload and restart → `noted`=1 at 2560 edges after the start edge.
- Re-arm: in DONE with `noted`=1, raise `fft_load` with zeros → `noted`=0 after that edge. Finish the zero load and start → `noted` stays 0.
